aes_sbox_arbiter: RTL and testbench



---
 rtl/aes_sbox_arbiter_if.sv | 48 ++++
 rtl/aes_sbox_arbiter.sv | 128 ++++++++++++
 tb/tb_aes_sbox_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/aes_sbox_arbiter_if.sv
// aes_sbox_arbiter_if
//   Bundles the two requester channels (key schedule K and round datapath D)
//   of the shared S-box bank, plus the busy flag.
//   Handshake: a transfer happens on a rising clk edge where valid & ready
//   are both 1. The producer holds valid/data stable until that edge; ready
//   never depends on anything but the consumer's state and the valids.
//   Ports per channel x in {k, d}:
//     x_req_valid/x_req_ready/x_req_data : word to substitute
//     x_rsp_valid/x_rsp_ready/x_rsp_data : substituted word
//     busy                               : output stage holds an undelivered result
//   Modports: slave = arbiter side, master = requester/bench side.
interface aes_sbox_arbiter_if #(
  parameter int LANES = 4
);
  localparam int W = 8 * LANES;

  logic         k_req_valid;
  logic         k_req_ready;
  logic [W-1:0] k_req_data;
  logic         k_rsp_valid;
  logic         k_rsp_ready;
  logic [W-1:0] k_rsp_data;

  logic         d_req_valid;
  logic         d_req_ready;
  logic [W-1:0] d_req_data;
  logic         d_rsp_valid;
  logic         d_rsp_ready;
  logic [W-1:0] d_rsp_data;

  logic         busy;

  modport slave (
    input  k_req_valid, k_req_data, k_rsp_ready,
    input  d_req_valid, d_req_data, d_rsp_ready,
    output k_req_ready, k_rsp_valid, k_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output busy
  );

  modport master (
    output k_req_valid, k_req_data, k_rsp_ready,
    output d_req_valid, d_req_data, d_rsp_ready,
    input  k_req_ready, k_rsp_valid, k_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  busy
  );
endinterface

// File: rtl/aes_sbox_arbiter.sv
// aes_sbox_arbiter
//   Shares one word-wide bank of LANES forward AES S-boxes between the key
//   schedule (K, SubWord) and the round datapath (D, SubBytes on a column).
//   Request mux -> LANES byte S-boxes -> single output register, returned to
//   the owning requester. One word per cycle; a stalled owner blocks both.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : aes_sbox_arbiter_if.slave (K/D request and response channels, busy)
//   Parameters:
//     LANES   : number of byte S-boxes, word width W = 8*LANES
//     K_FIRST : 1 = K wins contention (fixed mode) / pointer resets to K
//   Optional build macro AES_SBOX_ARB_RR_EN: round-robin arbitration between
//   K and D; when undefined, fixed priority per K_FIRST and no pointer register.
module aes_sbox_arbiter #(
  parameter int LANES   = 4,
  parameter bit K_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_sbox_arbiter_if.slave  bus
);
  localparam int W = 8 * LANES;

  typedef enum logic {OWN_K = 1'b0, OWN_D = 1'b1} owner_e;

  // FIPS-197 forward S-box, entry 0 first.
  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  logic         out_valid;
  owner_e       out_owner;
  logic [W-1:0] out_data;

  logic         prio_k;     // 1: K wins when both requesters are valid
  logic         grant_k;
  logic         grant_d;
  logic         drain;
  logic         can_accept;
  logic         acc_k;
  logic         acc_d;
  logic         acc;
  logic [W-1:0] req_data;
  logic [W-1:0] sub_data;

`ifdef AES_SBOX_ARB_RR_EN
  // Pointer names the requester that wins the next contention; after every
  // acceptance it moves to the requester that was not granted.
  logic ptr_k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_k <= K_FIRST;
    end else if (acc) begin
      ptr_k <= acc_d;
    end
  end

  assign prio_k = ptr_k;
`else
  assign prio_k = K_FIRST;
`endif

  assign grant_k = bus.k_req_valid & (!bus.d_req_valid | prio_k);
  assign grant_d = bus.d_req_valid & (!bus.k_req_valid | !prio_k);

  assign drain      = out_valid & ((out_owner == OWN_D) ? bus.d_rsp_ready : bus.k_rsp_ready);
  assign can_accept = !out_valid | drain;

  // rst_n gates ready so nothing looks accepted while reset is held.
  assign acc_k = grant_k & can_accept & rst_n;
  assign acc_d = grant_d & can_accept & rst_n;
  assign acc   = acc_k | acc_d;

  assign bus.k_req_ready = acc_k;
  assign bus.d_req_ready = acc_d;

  assign req_data = grant_d ? bus.d_req_data : bus.k_req_data;

  always_comb begin
    sub_data = '0;
    for (int i = 0; i < LANES; i++) begin
      sub_data[8*i +: 8] = sbox(req_data[8*i +: 8]);
    end
  end

  // Accept wins over drain, so a new result replaces the delivered one
  // without a bubble even when the owner changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_owner <= OWN_K;
      out_data  <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_owner <= acc_d ? OWN_D : OWN_K;
      out_data  <= sub_data;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.k_rsp_valid = out_valid & (out_owner == OWN_K);
  assign bus.d_rsp_valid = out_valid & (out_owner == OWN_D);
  assign bus.k_rsp_data  = out_data;
  assign bus.d_rsp_data  = out_data;
  assign bus.busy        = out_valid;
endmodule

// File: tb/tb_aes_sbox_arbiter.sv
module tb_aes_sbox_arbiter;
  localparam int LANES = 4;
  localparam int W = 8 * LANES;

  logic clk;
  logic rst_n;

  aes_sbox_arbiter_if #(.LANES(LANES)) bus ();

  aes_sbox_arbiter #(.LANES(LANES), .K_FIRST(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic         kv;
    logic [W-1:0] kd;
    logic         dv;
    logic [W-1:0] dd;
    logic         krr;
    logic         drr;
    logic         ekr;
    logic         edr;
    logic         ekv;
    logic         edv;
    logic [W-1:0] edata;
    logic         ebusy;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic kv, input logic [W-1:0] kd,
                              input logic dv, input logic [W-1:0] dd,
                              input logic krr, input logic drr,
                              input logic ekr, input logic edr,
                              input logic ekv, input logic edv,
                              input logic [W-1:0] edata, input logic ebusy);
    vec_t v;
    v.kv = kv; v.kd = kd; v.dv = dv; v.dd = dd; v.krr = krr; v.drr = drr;
    v.ekr = ekr; v.edr = edr; v.ekv = ekv; v.edv = edv;
    v.edata = edata; v.ebusy = ebusy;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic kv, input logic [W-1:0] kd,
                       input logic dv, input logic [W-1:0] dd,
                       input logic krr, input logic drr);
    bus.k_req_valid = kv;
    bus.k_req_data  = kd;
    bus.d_req_valid = dv;
    bus.d_req_data  = dd;
    bus.k_rsp_ready = krr;
    bus.d_rsp_ready = drr;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ekr, input logic edr,
                            input logic ekv, input logic edv,
                            input logic [W-1:0] edata, input logic ebusy);
    chk({tag, " k_req_ready"}, W'(bus.k_req_ready), W'(ekr));
    chk({tag, " d_req_ready"}, W'(bus.d_req_ready), W'(edr));
    chk({tag, " k_rsp_valid"}, W'(bus.k_rsp_valid), W'(ekv));
    chk({tag, " d_rsp_valid"}, W'(bus.d_rsp_valid), W'(edv));
    chk({tag, " k_rsp_data"},  bus.k_rsp_data, edata);
    chk({tag, " d_rsp_data"},  bus.d_rsp_data, edata);
    chk({tag, " busy"},        W'(bus.busy), W'(ebusy));
  endtask

  // Drive at the falling edge, sample 1 ns later; the rising edge then commits.
  task automatic step(input logic kv, input logic [W-1:0] kd,
                      input logic dv, input logic [W-1:0] dd,
                      input logic krr, input logic drr);
    @(negedge clk);
    drive(kv, kd, dv, dd, krr, drr);
    #1;
  endtask

  // ---------------- scoreboard data ----------------
  localparam logic [W-1:0] K53 = 32'h53535353, DFF = 32'hffffffff;
  localparam logic [W-1:0] S53 = 32'hedededed, SFF = 32'h16161616;

  logic [W-1:0] last_contend;

  initial begin
    // Table: state entering row 0 holds a D result 0x16161616 from the
    // acceptance made on reset release.
    tbl[0] = mk(0, 0, 0, 0, 1, 1,  0, 0, 0, 1, SFF, 1);
`ifdef AES_SBOX_ARB_RR_EN
    tbl[1] = mk(1, K53, 1, DFF, 1, 1,  1, 0, 0, 0, SFF, 0);
    tbl[2] = mk(1, K53, 1, DFF, 1, 1,  0, 1, 1, 0, S53, 1);
    tbl[3] = mk(1, K53, 1, DFF, 1, 1,  1, 0, 0, 1, SFF, 1);
    tbl[4] = mk(1, K53, 1, DFF, 1, 1,  0, 1, 1, 0, S53, 1);
    tbl[5] = mk(0, 0, 0, 0, 1, 1,      0, 0, 0, 1, SFF, 1);
    last_contend = SFF;
`else
    tbl[1] = mk(1, K53, 1, DFF, 1, 1,  1, 0, 0, 0, SFF, 0);
    tbl[2] = mk(1, K53, 1, DFF, 1, 1,  1, 0, 1, 0, S53, 1);
    tbl[3] = mk(1, K53, 1, DFF, 1, 1,  1, 0, 1, 0, S53, 1);
    tbl[4] = mk(1, K53, 1, DFF, 1, 1,  1, 0, 1, 0, S53, 1);
    tbl[5] = mk(0, 0, 0, 0, 1, 1,      0, 0, 1, 0, S53, 1);
    last_contend = S53;
`endif
    tbl[6] = mk(0, 0, 1, 32'h00010203, 1, 1,  0, 1, 0, 0, last_contend, 0);
    tbl[7] = mk(0, 0, 0, 0, 1, 1,             0, 0, 0, 1, 32'h637c777b, 1);
    tbl[8] = mk(1, 32'hcf4f3c09, 0, 0, 1, 1,  1, 0, 0, 0, 32'h637c777b, 0);
    tbl[9] = mk(0, 0, 0, 0, 1, 1,             0, 0, 1, 0, 32'h8a84eb01, 1);

    // ---- reset held with both valids high ----
    rst_n = 1'b0;
    drive(1, K53, 1, DFF, 1, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0);

    // ---- release: lone D is accepted on the next edge ----
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, DFF, 1, 1);
    #1;
    check_outs("release", 0, 1, 0, 0, 0, 0);

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      step(tbl[i].kv, tbl[i].kd, tbl[i].dv, tbl[i].dd, tbl[i].krr, tbl[i].drr);
      check_outs($sformatf("row%0d", i), tbl[i].ekr, tbl[i].edr,
                 tbl[i].ekv, tbl[i].edv, tbl[i].edata, tbl[i].ebusy);
    end

    // ---- backpressure: D result stalls, K waits, then no-bubble handover ----
    step(0, 0, 1, 32'h11111111, 1, 0);
    check_outs("bp_acc", 0, 1, 0, 0, 32'h8a84eb01, 0);
    for (int c = 0; c < 3; c++) begin
      step(1, 32'h00000000, 0, 0, 1, 0);
      check_outs($sformatf("bp_stall%0d", c), 0, 0, 0, 1, 32'h82828282, 1);
    end
    step(1, 32'h00000000, 0, 0, 1, 1);
    check_outs("bp_handover", 1, 0, 0, 1, 32'h82828282, 1);
    step(0, 0, 0, 0, 1, 1);
    check_outs("bp_kresult", 0, 0, 1, 0, 32'h63636363, 1);

    // ---- reset mid-flight ----
    step(1, 32'h01010101, 0, 0, 0, 0);
    check_outs("mf_acc", 1, 0, 0, 0, 32'h63636363, 0);
    step(0, 0, 0, 0, 0, 0);
    check_outs("mf_pending", 0, 0, 1, 0, 32'h7c7c7c7c, 1);
    rst_n = 1'b0;
    #1;
    check_outs("mf_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 0, 0, 0);
      check_outs($sformatf("mf_after%0d", c), 0, 0, 0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
